mdl_slotgen: RTL and testbench

Parametrised successor to the fixed 32-slot timing generator. It derives phi1 and its positive/negative clock-enable pulses from the phiM enable, and runs a slot counter covering CH channels × OPS operators. From that counter it decodes channel/operator indices, programmable cycle taps, a byte strobe and DAC sample-and-hold strobes. It sits at the top of the synth core and feeds the LFO, PG, EG and OP pipelines.

---
 rtl/mdl_slotgen_if.sv | 38 +++
 rtl/mdl_slotgen.sv | 114 +++++++++++
 tb/tb_mdl_slotgen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdl_slotgen_if.sv
// Slot generator bundle: phiM enable and halt in, phi1 timing and slot decodes out.
// Widths follow the CH/OPS parameters of the slot generator instance it connects to.
interface mdl_slotgen_if #(
    parameter int CH  = 8,
    parameter int OPS = 4
);
    localparam int SLOTS = CH * OPS;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;

    logic           i_phiM_PCEN_n;
    logic           i_HALT;
    logic           o_phi1;
    logic           o_phi1_PCEN_n;
    logic           o_phi1_NCEN_n;
    logic [SW-1:0]  o_SLOT;
    logic [CHW-1:0] o_CH;
    logic [1:0]     o_OP;
    logic           o_CYCLE_A;
    logic           o_CYCLE_B_n;
    logic           o_CYCLE_BYTE;
    logic           o_FRAME;
    logic           o_SH1;
    logic           o_SH2;
    logic [15:0]    o_FRAMECNT;

    modport master (
        input  i_phiM_PCEN_n, i_HALT,
        output o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT, o_CH, o_OP,
               o_CYCLE_A, o_CYCLE_B_n, o_CYCLE_BYTE, o_FRAME, o_SH1, o_SH2, o_FRAMECNT
    );

    modport slave (
        output i_phiM_PCEN_n, i_HALT,
        input  o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT, o_CH, o_OP,
               o_CYCLE_A, o_CYCLE_B_n, o_CYCLE_BYTE, o_FRAME, o_SH1, o_SH2, o_FRAMECNT
    );
endinterface

// File: rtl/mdl_slotgen.sv
// Parametrised phi1 / slot timing generator for the synth core (CH x OPS slots).
// Optional 16-bit frame counter is built only when SLOTGEN_FRAMECNT_EN is defined.
module mdl_slotgen #(
    parameter int CH       = 8,
    parameter int OPS      = 4,
    parameter int TAP_A    = 12,
    parameter int TAP_B    = 5,
    parameter int SH1_SLOT = 0,
    parameter int SH2_SLOT = 16,
    parameter int SH_LEN   = 8
) (
    input  logic          i_EMUCLK,
    input  logic          i_MRST_n,
    mdl_slotgen_if.master bus
);
    localparam int SLOTS = CH * OPS;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

    logic           ce;
    logic           phi1;
    logic           armed;
    logic           pcen;
    logic           ncen;
    logic           adv;
    logic           load;
    logic [SW-1:0]  slot;
    logic [SW-1:0]  slot_nxt;
    logic [SW-1:0]  slot_load;
    logic [CHW-1:0] ch_q;
    logic [1:0]     op_q;
    logic           cyc_a_q;
    logic           cyc_b_n_q;
    logic           byte_q;
    logic           frame_q;
    logic           sh1_q;
    logic           sh2_q;

    function automatic logic win_hit(input logic [SW-1:0] s, input int start);
        int rel;
        rel = (int'(s) - (start % SLOTS) + SLOTS) % SLOTS;
        return rel < SH_LEN;
    endfunction

    function automatic logic tap_hit(input logic [SW-1:0] s, input int tap);
        return (int'(s) == tap) || (int'(s) == tap + SLOTS / 2);
    endfunction

    assign ce   = ~bus.i_phiM_PCEN_n;
    assign pcen = ce & ~phi1 & i_MRST_n;
    assign ncen = ce & phi1 & i_MRST_n;

    // The first phi1 rise after reset only arms the counter; slot 0 spans one full phi1 period.
    assign adv       = pcen & armed & ~bus.i_HALT;
    assign slot_nxt  = (slot == LAST) ? '0 : slot + SW'(1);
    assign slot_load = i_MRST_n ? slot_nxt : '0;
    assign load      = ~i_MRST_n | adv;

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            phi1  <= 1'b0;
            armed <= 1'b0;
        end else begin
            if (ce)
                phi1 <= ~phi1;
            if (pcen)
                armed <= 1'b1;
        end
    end

    // Decodes load from the same next-slot value as the counter, so they never lag o_SLOT.
    always_ff @(posedge i_EMUCLK) begin
        if (load) begin
            slot      <= slot_load;
            ch_q      <= CHW'(int'(slot_load) % CH);
            op_q      <= 2'(int'(slot_load) / CH);
            cyc_a_q   <= tap_hit(slot_load, TAP_A);
            cyc_b_n_q <= ~tap_hit(slot_load, TAP_B);
            byte_q    <= (int'(slot_load) % 8) == 7;
            frame_q   <= slot_load == LAST;
            sh1_q     <= win_hit(slot_load, SH1_SLOT);
            sh2_q     <= win_hit(slot_load, SH2_SLOT);
        end
    end

`ifdef SLOTGEN_FRAMECNT_EN
    logic [15:0] framecnt;

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n)
            framecnt <= 16'h0000;
        else if (adv && slot == LAST)
            framecnt <= framecnt + 16'd1;
    end

    assign bus.o_FRAMECNT = framecnt;
`else
    assign bus.o_FRAMECNT = 16'h0000;
`endif

    assign bus.o_phi1        = phi1;
    assign bus.o_phi1_PCEN_n = ~pcen;
    assign bus.o_phi1_NCEN_n = ~ncen;
    assign bus.o_SLOT        = slot;
    assign bus.o_CH          = ch_q;
    assign bus.o_OP          = op_q;
    assign bus.o_CYCLE_A     = cyc_a_q;
    assign bus.o_CYCLE_B_n   = cyc_b_n_q;
    assign bus.o_CYCLE_BYTE  = byte_q;
    assign bus.o_FRAME       = frame_q;
    assign bus.o_SH1         = sh1_q;
    assign bus.o_SH2         = sh2_q;
endmodule

// File: tb/tb_mdl_slotgen.sv
// Bench for mdl_slotgen: default 32-slot instance plus a 12-slot instance, checked
// against an event-counting reference model; honours SLOTGEN_FRAMECNT_EN.
module tb_mdl_slotgen;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce_n  = 1'b1;
    logic halt  = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mdl_slotgen_if #(.CH(8), .OPS(4)) bus_d ();
    mdl_slotgen_if #(.CH(4), .OPS(3)) bus_s ();

    assign bus_d.i_phiM_PCEN_n = ce_n;
    assign bus_d.i_HALT        = halt;
    assign bus_s.i_phiM_PCEN_n = ce_n;
    assign bus_s.i_HALT        = halt;

    mdl_slotgen u_dflt (
        .i_EMUCLK (clk),
        .i_MRST_n (rst_n),
        .bus      (bus_d.master)
    );

    mdl_slotgen #(
        .CH(4), .OPS(3), .TAP_A(2), .TAP_B(5), .SH1_SLOT(10), .SH2_SLOT(6), .SH_LEN(4)
    ) u_small (
        .i_EMUCLK (clk),
        .i_MRST_n (rst_n),
        .bus      (bus_s.master)
    );

`ifdef SLOTGEN_FRAMECNT_EN
    localparam logic [15:0] FC_AFTER_FREE_RUN = 16'd3;
`else
    localparam logic [15:0] FC_AFTER_FREE_RUN = 16'd0;
`endif

    // Reference model: phi1 level and the number of slot advances since reset.
    logic m_phi1  = 1'b0;
    logic m_first = 1'b1;
    int   m_adv   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phi1  <= 1'b0;
            m_first <= 1'b1;
            m_adv   <= 0;
        end else if (!ce_n) begin
            m_phi1 <= !m_phi1;
            if (!m_phi1) begin
                if (m_first)
                    m_first <= 1'b0;
                else if (!halt)
                    m_adv <= m_adv + 1;
            end
        end
    end

    function automatic logic [38:0] exp_vec(input int n, input int ch, input int ta,
                                            input int tbp, input int s1, input int s2,
                                            input int len);
        int s;
        logic sh1;
        logic sh2;
        logic [15:0] fc;
        s   = m_adv % n;
        sh1 = 1'b0;
        sh2 = 1'b0;
        for (int k = 0; k < len; k++) begin
            if ((s1 + k) % n == s) sh1 = 1'b1;
            if ((s2 + k) % n == s) sh2 = 1'b1;
        end
`ifdef SLOTGEN_FRAMECNT_EN
        fc = 16'((m_adv / n) % 65536);
`else
        fc = 16'h0000;
`endif
        return {m_phi1, !(!ce_n && !m_phi1 && rst_n), !(!ce_n && m_phi1 && rst_n),
                (s == ta || s == ta + n / 2), !(s == tbp || s == tbp + n / 2),
                (s % 8) == 7, s == n - 1, sh1, sh2,
                8'(s), 4'(s % ch), 2'(s / ch), fc};
    endfunction

    function automatic logic [38:0] exp_d();
        return exp_vec(32, 8, 12, 5, 0, 16, 8);
    endfunction

    function automatic logic [38:0] exp_s();
        return exp_vec(12, 4, 2, 5, 10, 6, 4);
    endfunction

    logic [38:0] act_d;
    logic [38:0] act_s;

    assign act_d = {bus_d.o_phi1, bus_d.o_phi1_PCEN_n, bus_d.o_phi1_NCEN_n, bus_d.o_CYCLE_A,
                    bus_d.o_CYCLE_B_n, bus_d.o_CYCLE_BYTE, bus_d.o_FRAME, bus_d.o_SH1,
                    bus_d.o_SH2, 8'(bus_d.o_SLOT), 4'(bus_d.o_CH), bus_d.o_OP,
                    bus_d.o_FRAMECNT};
    assign act_s = {bus_s.o_phi1, bus_s.o_phi1_PCEN_n, bus_s.o_phi1_NCEN_n, bus_s.o_CYCLE_A,
                    bus_s.o_CYCLE_B_n, bus_s.o_CYCLE_BYTE, bus_s.o_FRAME, bus_s.o_SH1,
                    bus_s.o_SH2, 8'(bus_s.o_SLOT), 4'(bus_s.o_CH), bus_s.o_OP,
                    bus_s.o_FRAMECNT};

    task automatic test_reset();
        rst_n = 1'b0;
        ce_n  = 1'b0;
        halt  = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (act_d !== exp_d()) begin
            n_fail++;
            $display("FAIL reset_dflt: got %h expected %h", act_d, exp_d());
        end
        n_chk++;
        if (act_s !== exp_s()) begin
            n_fail++;
            $display("FAIL reset_small: got %h expected %h", act_s, exp_s());
        end
        n_chk++;
        if ({bus_d.o_phi1, bus_d.o_phi1_PCEN_n, bus_d.o_phi1_NCEN_n, bus_d.o_SLOT} !== 8'b0_11_00000) begin
            n_fail++;
            $display("FAIL reset_state: got phi1/pcen/ncen/slot %b expected 0_11_00000",
                     {bus_d.o_phi1, bus_d.o_phi1_PCEN_n, bus_d.o_phi1_NCEN_n, bus_d.o_SLOT});
        end
        n_chk++;
        if ({bus_d.o_SH1, bus_d.o_SH2, bus_d.o_FRAMECNT} !== 18'h20000) begin
            n_fail++;
            $display("FAIL reset_decodes: got sh1/sh2/fc %h expected 20000",
                     {bus_d.o_SH1, bus_d.o_SH2, bus_d.o_FRAMECNT});
        end
    endtask

    task automatic test_free_run();
        int prev_s;
        prev_s = 0;
        rst_n  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ce_n = (i % 2) != 0;
            @(negedge clk);
            n_chk++;
            if (act_d !== exp_d()) begin
                n_fail++;
                $display("FAIL free_dflt cyc %0d: got %h expected %h", i, act_d, exp_d());
            end
            n_chk++;
            if (act_s !== exp_s()) begin
                n_fail++;
                $display("FAIL free_small cyc %0d: got %h expected %h", i, act_s, exp_s());
            end
            if (m_adv % 32 == 13) begin
                n_chk++;
                if ({bus_d.o_CH, bus_d.o_OP} !== 5'b101_01) begin
                    n_fail++;
                    $display("FAIL slot13_ch_op: got ch %0d op %0d expected ch 5 op 1",
                             bus_d.o_CH, bus_d.o_OP);
                end
            end
            if (m_adv % 32 == 28) begin
                n_chk++;
                if (bus_d.o_CYCLE_A !== 1'b1) begin
                    n_fail++;
                    $display("FAIL slot28_cycle_a: got %b expected 1", bus_d.o_CYCLE_A);
                end
            end
            if (prev_s == 11 && m_adv % 12 != 11) begin
                n_chk++;
                if (bus_s.o_SLOT !== 4'd0) begin
                    n_fail++;
                    $display("FAIL small_wrap: got %0d expected 0", bus_s.o_SLOT);
                end
            end
            prev_s = m_adv % 12;
        end
        n_chk++;
        if (bus_d.o_FRAMECNT !== FC_AFTER_FREE_RUN) begin
            n_fail++;
            $display("FAIL framecnt_3_frames: got %0d expected %0d",
                     bus_d.o_FRAMECNT, FC_AFTER_FREE_RUN);
        end
    endtask

    task automatic test_halt();
        bit   found;
        int   tog;
        logic last_phi;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            ce_n = ~ce_n;
            @(negedge clk);
            if (m_adv % 32 == 9) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL halt_reach_slot9: got timeout expected slot 9");
        end
        halt     = 1'b1;
        tog      = 0;
        last_phi = bus_d.o_phi1;
        for (int i = 0; i < 40; i++) begin
            ce_n = ~ce_n;
            @(negedge clk);
            if (bus_d.o_phi1 !== last_phi) tog++;
            last_phi = bus_d.o_phi1;
            n_chk++;
            if (bus_d.o_SLOT !== 5'd9 || act_d !== exp_d() || act_s !== exp_s()) begin
                n_fail++;
                $display("FAIL halt_hold cyc %0d: got slot %0d vec %h expected slot 9 vec %h",
                         i, bus_d.o_SLOT, act_d, exp_d());
            end
        end
        n_chk++;
        if (tog !== 20) begin
            n_fail++;
            $display("FAIL halt_phi1_toggles: got %0d expected 20", tog);
        end
        halt  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            ce_n = ~ce_n;
            @(negedge clk);
            if (m_adv % 32 != 9) found = 1'b1;
        end
        n_chk++;
        if (!found || bus_d.o_SLOT !== 5'd10) begin
            n_fail++;
            $display("FAIL halt_resume: got slot %0d expected 10", bus_d.o_SLOT);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            ce_n = ~ce_n;
            @(negedge clk);
            if (m_adv % 32 == 20) found = 1'b1;
        end
        n_chk++;
        if (!found || bus_d.o_SLOT !== 5'd20) begin
            n_fail++;
            $display("FAIL rst_mid_reach: got slot %0d expected 20", bus_d.o_SLOT);
        end
        halt  = 1'b1;
        ce_n  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus_d.o_SLOT, bus_d.o_phi1, bus_d.o_phi1_PCEN_n, bus_d.o_phi1_NCEN_n,
             bus_d.o_FRAMECNT, bus_s.o_SLOT} !== {5'd0, 3'b011, 16'h0000, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_state: got slot %0d phi1 %b pcen %b ncen %b fc %0d sslot %0d expected 0 0 1 1 0 0",
                     bus_d.o_SLOT, bus_d.o_phi1, bus_d.o_phi1_PCEN_n, bus_d.o_phi1_NCEN_n,
                     bus_d.o_FRAMECNT, bus_s.o_SLOT);
        end
        rst_n = 1'b1;
        halt  = 1'b0;
        ce_n  = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus_d.o_phi1, bus_d.o_SLOT} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL first_rise: got phi1 %b slot %0d expected phi1 1 slot 0",
                     bus_d.o_phi1, bus_d.o_SLOT);
        end
        ce_n = 1'b1;
    endtask

    task automatic test_ce_low();
        for (int i = 0; i < 12; i++) begin
            ce_n = 1'b1;
            halt = ($urandom % 2) != 0;
            @(negedge clk);
            n_chk++;
            if (act_d !== exp_d() || act_s !== exp_s()) begin
                n_fail++;
                $display("FAIL ce_low cyc %0d: got %h/%h expected %h/%h",
                         i, act_d, act_s, exp_d(), exp_s());
            end
        end
        halt = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ce_n  = ($urandom % 3) == 0;
            halt  = ($urandom % 6) == 0;
            rst_n = ($urandom % 150) != 0;
            @(negedge clk);
            n_chk++;
            if (act_d !== exp_d()) begin
                n_fail++;
                $display("FAIL rand_dflt cyc %0d: got %h expected %h", i, act_d, exp_d());
            end
            n_chk++;
            if (act_s !== exp_s()) begin
                n_fail++;
                $display("FAIL rand_small cyc %0d: got %h expected %h", i, act_s, exp_s());
            end
        end
        rst_n = 1'b1;
        halt  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_halt();
        test_reset_mid();
        test_ce_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
